apb_arb_master: RTL

Round-robin arbiter and APB master that shares one APB slave port (8-bit data, 32-bit address) between NREQ local requesters. Each requester presents a single read or write; the block grants one at a time and drives the APB SETUP/ACCESS phases. It waits for `pready`, then returns read data and the slave error flag to the granted requester. It sits between on-chip initiators (test sequencers, config engines) and the APB slave memory.

---
 rtl/apb_arb_master.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_arb_master.sv
// apb_arb_master: round-robin arbiter in front of a single APB master port.
// NREQ requesters each post one read or write. The winner is driven through
// the APB SETUP and ACCESS phases. The completion is returned as a one-cycle
// done pulse, together with rdata and err.
// Optional feature: define APB_ARB_TIMEOUT_EN to abandon an ACCESS phase after
// TIMEOUT wait cycles. The abandoned transfer completes with err=1.
module apb_arb_master #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_write,
    input  logic [NREQ*32-1:0]  req_addr,
    input  logic [NREQ*8-1:0]   req_wdata,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          rdata,
    output logic                err,
    output logic [31:0]         paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [7:0]          pwdata,
    input  logic [7:0]          prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [31:0]     paddr_q, paddr_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [7:0]      pwdata_q, pwdata_d;

    logic [31:0]     addr_arr  [NREQ];
    logic [7:0]      wdata_arr [NREQ];
    logic [NREQ-1:0] eligible;
    logic            any_elig;
    logic [IW-1:0]   pick;
    logic [IW:0]     cand;
    logic [IW-1:0]   next_ptr;
    logic            tmo_hit;

    // Split the packed request buses into per-requester lanes.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[32*gi +: 32];
        assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end

    // Round-robin search upward from ptr. A requester whose done is showing
    // this cycle is masked, because it has not yet had a chance to drop req.
    always_comb begin
        eligible = req & ~done_q;
        any_elig = 1'b0;
        pick     = ptr_q;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!any_elig && eligible[cand[IW-1:0]]) begin
                any_elig = 1'b1;
                pick     = cand[IW-1:0];
            end
        end
    end

    assign next_ptr = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + 1'b1;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // An abandon happens on the wait cycle that would bring the count to TIMEOUT.
    // A pready on that same cycle takes priority.
    assign tmo_hit = (state_q == ST_ACCESS) && !pready && (tmo_q == TW'(TIMEOUT - 1));

    // The wait counter clears while in SETUP, so it starts at zero in ACCESS.
    // It then counts the ACCESS cycles in which pready is low.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_SETUP) begin
            tmo_d = '0;
        end else if (state_q == ST_ACCESS && !pready) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign tmo_hit        = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_elig) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || tmo_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs. The APB strobes are derived from
    // the next state, so they are aligned with the phase they belong to.
    always_comb begin
        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        done_d    = '0;
        rdata_d   = 8'h00;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    grant_d  = pick;
                    paddr_d  = addr_arr[pick];
                    pwdata_d = wdata_arr[pick];
                    pwrite_d = req_write[pick];
                end
            end
            ST_ACCESS: begin
                if (pready) begin
                    done_d[grant_q] = 1'b1;
                    err_d           = pslverr;
                    rdata_d         = pwrite_q ? 8'h00 : prdata;
                    ptr_d           = next_ptr;
                end else if (tmo_hit) begin
                    done_d[grant_q] = 1'b1;
                    err_d           = 1'b1;
                    ptr_d           = next_ptr;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ptr_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
            paddr_q   <= 32'h0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 8'h00;
        end else begin
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign paddr   = paddr_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign pwdata  = pwdata_q;

endmodule
